vga_timing_ctrl: RTL and testbench
==================================

# vga_timing_ctrl

Sequencer for the VGA display path of the AHB VGA peripheral. It owns the pixel-rate prescaler and the horizontal and vertical timing state machines. It generates HSYNC, VSYNC, the display-enable window and the active pixel coordinates consumed by the frame-buffer read and text/pixel pipeline. It replaces the ad-hoc cascade of free-running counters with one block that knows the phase of every line and frame.

## Interface
- PIX_DIV, 2: CLK cycles per pixel (≥1).
- H_ACTIVE, 640: active pixels per line. H_FP, 16: front porch. H_SYNC, 96: sync width. H_BP, 48: back porch.
- V_ACTIVE, 480: active lines per frame. V_FP, 10. V_SYNC, 2. V_BP, 33 (lines).
- SYNC_POL, 0: asserted level of HSYNC/VSYNC (0 = active-low).
- COORD_WIDTH, 10: width of PIX_X/PIX_Y. Must hold H_ACTIVE-1 and V_ACTIVE-1.
- Every phase length is ≥1.

- CLK  in  1  system clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- ENABLE  in  1  run; low freezes all state.
- PIX_TICK  out  1  pixel strobe, one CLK wide.
- HSYNC  out  1  horizontal sync, polarity per SYNC_POL.
- VSYNC  out  1  vertical sync, polarity per SYNC_POL.
- DISP_EN  out  1  high while both axes are in their active phase.
- PIX_X  out  COORD_WIDTH  active column; 0 outside the horizontal active phase.
- PIX_Y  out  COORD_WIDTH  active row; 0 outside the vertical active phase.
- LINE_END  out  1  one-CLK pulse on the last pixel tick of a line.
- FRAME_END  out  1  one-CLK pulse on the last pixel tick of a frame.

## Operation
- Prescaler counts 0..PIX_DIV-1, advances only when ENABLE=1, and wraps to 0.
- PIX_TICK = ENABLE && prescaler==PIX_DIV-1. It is combinational from registered state. With PIX_DIV=1 it equals ENABLE.
- H FSM states are H_ACT→H_FP→H_SYNC→H_BP→H_ACT. Each state has a phase counter 0..len-1 that advances on PIX_TICK. On the tick where the counter equals len-1, the FSM moves to the next state and the counter clears.
- V FSM states are V_ACT→V_FP→V_SYNC→V_BP→V_ACT, using the same rule. It advances only on LINE_END.
- LINE_END = PIX_TICK && H_BP && hphase==H_BP-1.
- FRAME_END = LINE_END && V_BP && vphase==V_BP-1.
- HSYNC = SYNC_POL when in H_SYNC, otherwise ~SYNC_POL. VSYNC is the same, driven by V_SYNC.
- DISP_EN = (H_ACT && V_ACT).
- PIX_X = hphase in H_ACT, otherwise 0.
- PIX_Y = vphase in V_ACT, otherwise 0.
- Totals: H_TOTAL = sum of the four H lengths (800). V_TOTAL = sum of the four V lengths (525). One frame = H_TOTAL·V_TOTAL·PIX_DIV CLKs.
- Counters never exceed len-1. No arithmetic wraps beyond phase boundaries.

## Timing
- Reset values: prescaler 0, H_ACT/V_ACT, both phases 0, HSYNC=VSYNC=~SYNC_POL, PIX_X=PIX_Y=0, PIX_TICK=0 (prescaler≠PIX_DIV-1 or ENABLE=0), LINE_END=FRAME_END=0.
- DISP_EN comes out of reset high, since pixel (0,0) is active.
- The first PIX_TICK occurs PIX_DIV cycles after RESET falls with ENABLE=1. PIX_X becomes 1 on the CLK following that tick.
- HSYNC, VSYNC, DISP_EN and PIX_X/Y change exactly one edge after the PIX_TICK that advances them. They are decoded from registers only, so they are glitch-free relative to CLK.
- The vertical step and horizontal wrap happen on the same edge. PIX_Y updates on the same edge PIX_X returns to 0.
- ENABLE=0 holds the prescaler, both FSMs and all outputs. PIX_TICK, LINE_END and FRAME_END are forced 0. Resuming continues from the held point with no lost or extra ticks.
- RESET mid-line or mid-frame returns everything to reset values on the next edge. RESET has priority over ENABLE.

## Test plan
- Reset: assert RESET for 3 CLK with ENABLE=1. Check HSYNC=VSYNC=1, DISP_EN=1, PIX_X=PIX_Y=0, and no LINE_END/FRAME_END.
- Default line (PIX_DIV=2): the first HSYNC low occurs 656·2 CLKs after reset release and lasts 192 CLKs. LINE_END period is 1600 CLKs. DISP_EN is high 1280 CLKs per active line.
- Small config (PIX_DIV=1, H=4/1/2/1, V=3/1/1/1): PIX_X sequence is 0,1,2,3,0,0,0,0 with DISP_EN 1,1,1,1,0,0,0,0. HSYNC is low on cycles 5-6 of each 8-cycle line. VSYNC is low for line 4 (8 CLKs). FRAME_END fires once every 48 CLKs.
- ENABLE gap: drop ENABLE for 7 CLK mid-H_SYNC in the small config. HSYNC stays low throughout. The total HSYNC-low time equals 2 ticks plus the 7 held CLKs, and there is no extra LINE_END.
- Reset mid-frame: in the small config, assert RESET at line 4 (V_SYNC). VSYNC returns to 1 the next edge, and the next FRAME_END arrives 48 CLKs after release.
- Frame count (default params): FRAME_END spacing is exactly 840000 CLKs over 2 frames. PIX_Y peaks at 479 and PIX_X peaks at 639.

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// VGA timing sequencer: pixel prescaler plus horizontal/vertical phase FSMs producing
// sync, display-enable, active coordinates and line/frame end strobes.
module vga_timing_ctrl #(
    parameter int   PIX_DIV     = 2,
    parameter int   H_ACTIVE    = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_ACTIVE    = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter logic SYNC_POL    = 1'b0,
    parameter int   COORD_WIDTH = 10
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   ENABLE,
    output logic                   PIX_TICK,
    output logic                   HSYNC,
    output logic                   VSYNC,
    output logic                   DISP_EN,
    output logic [COORD_WIDTH-1:0] PIX_X,
    output logic [COORD_WIDTH-1:0] PIX_Y,
    output logic                   LINE_END,
    output logic                   FRAME_END
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int PW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PIX_DIV - 1);

    typedef enum logic [1:0] {H_ACT_S = 2'd0, H_FP_S = 2'd1, H_SYNC_S = 2'd2, H_BP_S = 2'd3} h_state_t;
    typedef enum logic [1:0] {V_ACT_S = 2'd0, V_FP_S = 2'd1, V_SYNC_S = 2'd2, V_BP_S = 2'd3} v_state_t;

    function automatic logic [HW-1:0] h_last(input h_state_t s);
        case (s)
            H_ACT_S:  return HW'(H_ACTIVE - 1);
            H_FP_S:   return HW'(H_FP - 1);
            H_SYNC_S: return HW'(H_SYNC - 1);
            default:  return HW'(H_BP - 1);
        endcase
    endfunction

    function automatic h_state_t h_next(input h_state_t s);
        case (s)
            H_ACT_S:  return H_FP_S;
            H_FP_S:   return H_SYNC_S;
            H_SYNC_S: return H_BP_S;
            default:  return H_ACT_S;
        endcase
    endfunction

    function automatic logic [VW-1:0] v_last(input v_state_t s);
        case (s)
            V_ACT_S:  return VW'(V_ACTIVE - 1);
            V_FP_S:   return VW'(V_FP - 1);
            V_SYNC_S: return VW'(V_SYNC - 1);
            default:  return VW'(V_BP - 1);
        endcase
    endfunction

    function automatic v_state_t v_next(input v_state_t s);
        case (s)
            V_ACT_S:  return V_FP_S;
            V_FP_S:   return V_SYNC_S;
            V_SYNC_S: return V_BP_S;
            default:  return V_ACT_S;
        endcase
    endfunction

    logic [PW-1:0]          presc_q, presc_d;
    h_state_t               h_state_q, h_state_d;
    v_state_t               v_state_q, v_state_d;
    logic [HW-1:0]          hphase_q, hphase_d;
    logic [VW-1:0]          vphase_q, vphase_d;
    logic                   hsync_q, hsync_d;
    logic                   vsync_q, vsync_d;
    logic                   disp_en_q, disp_en_d;
    logic [COORD_WIDTH-1:0] pix_x_q, pix_x_d;
    logic [COORD_WIDTH-1:0] pix_y_q, pix_y_d;
    logic                   tick_s, line_end_s, frame_end_s;

    // Strobes are decoded from registered state and gated by ENABLE so a freeze suppresses them.
    assign tick_s      = ENABLE && (presc_q == PRE_LAST);
    assign line_end_s  = tick_s && (h_state_q == H_BP_S) && (hphase_q == h_last(H_BP_S));
    assign frame_end_s = line_end_s && (v_state_q == V_BP_S) && (vphase_q == v_last(V_BP_S));

    // Next-state: prescaler, both phase FSMs, and the output values they imply.
    always_comb begin
        presc_d   = presc_q;
        h_state_d = h_state_q;
        hphase_d  = hphase_q;
        v_state_d = v_state_q;
        vphase_d  = vphase_q;

        if (ENABLE) begin
            if (presc_q == PRE_LAST) begin
                presc_d = {PW{1'b0}};
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end else begin
            presc_d = presc_q;
        end

        if (tick_s) begin
            if (hphase_q == h_last(h_state_q)) begin
                h_state_d = h_next(h_state_q);
                hphase_d  = {HW{1'b0}};
            end else begin
                hphase_d  = hphase_q + HW'(1);
            end
        end else begin
            hphase_d = hphase_q;
        end

        // The vertical axis steps on the same edge the horizontal axis wraps.
        if (line_end_s) begin
            if (vphase_q == v_last(v_state_q)) begin
                v_state_d = v_next(v_state_q);
                vphase_d  = {VW{1'b0}};
            end else begin
                vphase_d  = vphase_q + VW'(1);
            end
        end else begin
            vphase_d = vphase_q;
        end

        hsync_d   = (h_state_d == H_SYNC_S) ? SYNC_POL : ~SYNC_POL;
        vsync_d   = (v_state_d == V_SYNC_S) ? SYNC_POL : ~SYNC_POL;
        disp_en_d = (h_state_d == H_ACT_S) && (v_state_d == V_ACT_S);
        pix_x_d   = (h_state_d == H_ACT_S) ? COORD_WIDTH'(hphase_d) : {COORD_WIDTH{1'b0}};
        pix_y_d   = (v_state_d == V_ACT_S) ? COORD_WIDTH'(vphase_d) : {COORD_WIDTH{1'b0}};
    end

    // State and registered-output flops with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            presc_q   <= {PW{1'b0}};
            h_state_q <= H_ACT_S;
            hphase_q  <= {HW{1'b0}};
            v_state_q <= V_ACT_S;
            vphase_q  <= {VW{1'b0}};
            hsync_q   <= ~SYNC_POL;
            vsync_q   <= ~SYNC_POL;
            disp_en_q <= 1'b1;
            pix_x_q   <= {COORD_WIDTH{1'b0}};
            pix_y_q   <= {COORD_WIDTH{1'b0}};
        end else begin
            presc_q   <= presc_d;
            h_state_q <= h_state_d;
            hphase_q  <= hphase_d;
            v_state_q <= v_state_d;
            vphase_q  <= vphase_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            disp_en_q <= disp_en_d;
            pix_x_q   <= pix_x_d;
            pix_y_q   <= pix_y_d;
        end
    end

    assign PIX_TICK  = tick_s;
    assign LINE_END  = line_end_s;
    assign FRAME_END = frame_end_s;
    assign HSYNC     = hsync_q;
    assign VSYNC     = vsync_q;
    assign DISP_EN   = disp_en_q;
    assign PIX_X     = pix_x_q;
    assign PIX_Y     = pix_y_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl: default 640x480 line timing, a tiny PIX_DIV=1 mode
// with enable gap and mid-frame reset, and a PIX_DIV=3 active-high-sync mode over two frames.
module tb_vga_timing_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Default-parameter instance
    logic d_rst = 1'b1, d_en = 1'b1;
    logic d_tick, d_hs, d_vs, d_de, d_le, d_fe;
    logic [9:0] d_px, d_py;
    vga_timing_ctrl u_dflt (
        .CLK(clk), .RESET(d_rst), .ENABLE(d_en), .PIX_TICK(d_tick), .HSYNC(d_hs), .VSYNC(d_vs),
        .DISP_EN(d_de), .PIX_X(d_px), .PIX_Y(d_py), .LINE_END(d_le), .FRAME_END(d_fe));

    // Tiny instance: 8-pixel lines, 6-line frames, one pixel per clock
    logic s_rst = 1'b1, s_en = 1'b1;
    logic s_tick, s_hs, s_vs, s_de, s_le, s_fe;
    logic [3:0] s_px, s_py;
    vga_timing_ctrl #(.PIX_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0), .COORD_WIDTH(4)) u_small (
        .CLK(clk), .RESET(s_rst), .ENABLE(s_en), .PIX_TICK(s_tick), .HSYNC(s_hs), .VSYNC(s_vs),
        .DISP_EN(s_de), .PIX_X(s_px), .PIX_Y(s_py), .LINE_END(s_le), .FRAME_END(s_fe));

    // Mid instance: 12-pixel lines, 10-line frames, 3 clocks per pixel, active-high sync
    logic m_rst = 1'b1, m_en = 1'b1;
    logic m_tick, m_hs, m_vs, m_de, m_le, m_fe;
    logic [3:0] m_px, m_py;
    vga_timing_ctrl #(.PIX_DIV(3), .H_ACTIVE(5), .H_FP(2), .H_SYNC(3), .H_BP(2),
                      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b1), .COORD_WIDTH(4)) u_mid (
        .CLK(clk), .RESET(m_rst), .ENABLE(m_en), .PIX_TICK(m_tick), .HSYNC(m_hs), .VSYNC(m_vs),
        .DISP_EN(m_de), .PIX_X(m_px), .PIX_Y(m_py), .LINE_END(m_le), .FRAME_END(m_fe));

    int sk = 0;  // enabled edges since the tiny instance left reset

    // Closed-form expectation for the tiny instance after sk enabled pixel edges.
    task automatic s_check(input logic en);
        int hpos, line;
        hpos = sk % 8;
        line = (sk / 8) % 6;
        chk_val("s_px",   32'(s_px), (hpos < 4) ? hpos : 0);
        chk_val("s_py",   32'(s_py), (line < 3) ? line : 0);
        chk_val("s_de",   32'(s_de), (hpos < 4 && line < 3) ? 1 : 0);
        chk_val("s_hs",   32'(s_hs), (hpos == 5 || hpos == 6) ? 0 : 1);
        chk_val("s_vs",   32'(s_vs), (line == 4) ? 0 : 1);
        chk_val("s_tick", 32'(s_tick), en ? 1 : 0);
        chk_val("s_le",   32'(s_le), (en && hpos == 7) ? 1 : 0);
        chk_val("s_fe",   32'(s_fe), (en && hpos == 7 && line == 5) ? 1 : 0);
    endtask

    task automatic s_cycle(input logic en, input logic rst);
        s_en  = en;
        s_rst = rst;
        @(posedge clk);
        if (rst) sk = 0;
        else if (en) sk++;
        #1;
        s_check(en);
    endtask

    initial begin
        int hs_first, hs_low, de_cnt, le1, le2, fe_cnt, px_max, m_fe1, m_fe2, m_px_max, m_py_max;
        int m_hs_hi, m_vs_hi, m_le_cnt, gap_low, gap_le, c, fe_at;

        // ---------------- default parameters ----------------
        repeat (3) @(posedge clk);
        #1;
        chk_val("rst_hs", 32'(d_hs), 1);
        chk_val("rst_vs", 32'(d_vs), 1);
        chk_val("rst_de", 32'(d_de), 1);
        chk_val("rst_px", 32'(d_px), 0);
        chk_val("rst_py", 32'(d_py), 0);
        chk_val("rst_le", 32'(d_le), 0);
        chk_val("rst_fe", 32'(d_fe), 0);
        chk_val("rst_tick", 32'(d_tick), 0);
        d_rst = 1'b0;
        hs_first = -1; hs_low = 0; de_cnt = 0; le1 = -1; le2 = -1; fe_cnt = 0; px_max = 0;
        for (int k = 1; k <= 3300; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                chk_val("first_tick", 32'(d_tick), 1);
                chk_val("px_at_tick", 32'(d_px), 0);
            end
            if (k == 2) chk_val("px_after_tick", 32'(d_px), 1);
            if (k == 1600) begin
                chk_val("py_line1", 32'(d_py), 1);
                chk_val("px_wrap", 32'(d_px), 0);
            end
            if (!d_hs && hs_first < 0) hs_first = k;
            if (k >= 1600 && k < 3200) begin
                if (!d_hs) hs_low++;
                if (d_de) de_cnt++;
            end
            if (d_le) begin
                if (le1 < 0) le1 = k;
                else if (le2 < 0) le2 = k;
            end
            if (d_fe) fe_cnt++;
            if (int'(d_px) > px_max) px_max = int'(d_px);
        end
        chk_val("hs_first", hs_first, 1312);
        chk_val("hs_width", hs_low, 192);
        chk_val("de_per_line", de_cnt, 1280);
        chk_val("le_first", le1, 1599);
        chk_val("le_period", le2 - le1, 1600);
        chk_val("d_fe_none", fe_cnt, 0);
        chk_val("d_px_peak", px_max, 639);

        // ---------------- PIX_DIV=3, active-high sync ----------------
        m_rst = 1'b0;
        m_fe1 = -1; m_fe2 = -1; m_px_max = 0; m_py_max = 0; m_hs_hi = 0; m_vs_hi = 0; m_le_cnt = 0;
        for (int k = 1; k <= 760; k++) begin
            @(posedge clk);
            #1;
            if (m_fe) begin
                if (m_fe1 < 0) m_fe1 = k;
                else if (m_fe2 < 0) m_fe2 = k;
            end
            if (k <= 36 && m_hs) m_hs_hi++;
            if (k <= 360 && m_vs) m_vs_hi++;
            if (k <= 360 && m_le) m_le_cnt++;
            if (int'(m_px) > m_px_max) m_px_max = int'(m_px);
            if (int'(m_py) > m_py_max) m_py_max = int'(m_py);
        end
        chk_val("m_fe_first", m_fe1, 359);
        chk_val("m_fe_period", m_fe2 - m_fe1, 360);
        chk_val("m_hs_hi", m_hs_hi, 9);
        chk_val("m_vs_hi", m_vs_hi, 72);
        chk_val("m_le_cnt", m_le_cnt, 10);
        chk_val("m_px_peak", m_px_max, 4);
        chk_val("m_py_peak", m_py_max, 3);

        // ---------------- tiny config ----------------
        s_cycle(1'b1, 1'b1);
        repeat (101) s_cycle(1'b1, 1'b0);      // two frames, then into H_SYNC (hpos 5)
        gap_low = s_hs ? 0 : 1;
        gap_le  = 0;
        repeat (7) begin
            s_cycle(1'b0, 1'b0);
            if (!s_hs) gap_low++;
            if (s_le) gap_le++;
        end
        repeat (3) begin
            s_cycle(1'b1, 1'b0);
            if (!s_hs) gap_low++;
            if (s_le) gap_le++;
        end
        chk_val("gap_hs_low", gap_low, 9);
        chk_val("gap_le", gap_le, 1);

        repeat (26) s_cycle(1'b1, 1'b0);       // sk=130: middle of the V_SYNC line
        chk_val("pre_rst_vs", 32'(s_vs), 0);
        s_cycle(1'b1, 1'b1);
        chk_val("post_rst_vs", 32'(s_vs), 1);
        c = 1; fe_at = -1;
        while (fe_at < 0 && c < 80) begin
            s_cycle(1'b1, 1'b0);
            c++;
            if (s_fe) fe_at = c;
        end
        chk_val("fe_after_rst", fe_at, 48);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
